// File: rtl/bip_pkg.sv
// bip_pkg: shared opcode, accumulator-select and FSM state encodings
package bip_pkg;
  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_JMP  = 5'b01000,
    OP_BEQZ = 5'b01001
  } opcode_e;
  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALTED  = 2'd3
  } state_e;
endpackage

// File: rtl/bip_opcode_decoder.sv
// bip_opcode_decoder: combinational opcode to datapath-control decode
module bip_opcode_decoder
  import bip_pkg::*;
#(
  parameter int NB_OPCODE     = 5,
  parameter int NB_SELECTOR_A = 2
) (
  input  logic [NB_OPCODE-1:0]     opcode,
  output logic [NB_SELECTOR_A-1:0] sel_a,
  output logic                     sel_b,
  output logic                     enb_acc,
  output logic                     operation,
  output logic                     wr_enb_ram,
  output logic                     rd_enb_ram,
  output logic                     jump,
  output logic                     branch,
  output logic                     halt,
  output logic                     illegal
);
  opcode_e op;
  assign op = opcode_e'(opcode);
  always_comb begin
    sel_a      = '0;
    sel_b      = 1'b0;
    enb_acc    = 1'b0;
    operation  = 1'b0;
    wr_enb_ram = 1'b0;
    rd_enb_ram = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    halt       = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_HLT:  halt = 1'b1;
      OP_STO:  wr_enb_ram = 1'b1;
      OP_LD: begin
        rd_enb_ram = 1'b1;
        sel_a      = NB_SELECTOR_A'(SEL_A_RAM);
        enb_acc    = 1'b1;
      end
      OP_LDI: begin
        sel_a   = NB_SELECTOR_A'(SEL_A_IMM);
        enb_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        rd_enb_ram = 1'b1;
        sel_a      = NB_SELECTOR_A'(SEL_A_ALU);
        enb_acc    = 1'b1;
        operation  = op == OP_SUB;
      end
      OP_ADDI, OP_SUBI: begin
        sel_a     = NB_SELECTOR_A'(SEL_A_ALU);
        sel_b     = 1'b1;
        enb_acc   = 1'b1;
        operation = op == OP_SUBI;
      end
      OP_JMP:  jump = 1'b1;
      OP_BEQZ: branch = 1'b1;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/bip_sequencer.sv
// bip_sequencer: two-cycle fetch/execute control unit with program counter
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_OPCODE      = 5,
  parameter int NB_ADDR        = 11,
  parameter int NB_SELECTOR_A  = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_INSTRUCTION-1:0] i_instruction,
  input  logic                      i_acc_zero,
  output logic [NB_ADDR-1:0]        o_address,
  output logic [NB_ADDR-1:0]        o_operand,
  output logic [NB_SELECTOR_A-1:0]  o_sel_a,
  output logic                      o_sel_b,
  output logic                      o_enb_acc,
  output logic                      o_operation,
  output logic                      o_wr_enb_ram,
  output logic                      o_rd_enb_ram,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_illegal
);
  state_e state, next_state;
  logic [NB_ADDR-1:0] pc, next_pc, operand;
  logic [NB_SELECTOR_A-1:0] sel_a;
  logic sel_b, enb_acc, operation, wr_enb_ram, rd_enb_ram, jump, branch, halt, illegal, exec;
  assign operand = i_instruction[NB_ADDR-1:0];
  assign exec    = state == S_EXECUTE;
  bip_opcode_decoder #(.NB_OPCODE(NB_OPCODE), .NB_SELECTOR_A(NB_SELECTOR_A)) decoder (
    .opcode     (i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE]),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .enb_acc    (enb_acc),
    .operation  (operation),
    .wr_enb_ram (wr_enb_ram),
    .rd_enb_ram (rd_enb_ram),
    .jump       (jump),
    .branch     (branch),
    .halt       (halt),
    .illegal    (illegal)
  );
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  // PC increment wraps naturally at 2^NB_ADDR
  always_comb begin
    next_state = state;
    next_pc    = pc;
    case (state)
      S_IDLE: if (i_start) begin
        next_state = S_FETCH;
        next_pc    = '0;
      end
      S_FETCH: next_state = S_EXECUTE;
      S_EXECUTE: begin
        next_state = halt ? S_HALTED : S_FETCH;
        next_pc    = halt ? pc : (jump || (branch && i_acc_zero)) ? operand : pc + NB_ADDR'(1);
      end
      default: next_state = S_IDLE;
    endcase
  end
  assign o_address    = pc;
  assign o_operand    = exec ? operand : '0;
  assign o_sel_a      = exec ? sel_a : '0;
  assign o_sel_b      = exec && sel_b;
  assign o_enb_acc    = exec && enb_acc;
  assign o_operation  = exec && operation;
  assign o_wr_enb_ram = exec && wr_enb_ram;
  assign o_rd_enb_ram = exec && rd_enb_ram;
  assign o_busy       = state == S_FETCH || exec;
  assign o_done       = exec && halt;
  assign o_illegal    = exec && illegal;
endmodule

// File: tb/tb_bip_sequencer.sv
// tb_bip_sequencer: per-cycle directed vectors plus mid-instruction reset sequence
module tb_bip_sequencer;
  logic i_clock = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_acc_zero = 1'b0;
  logic [15:0] i_instruction = '0;
  logic [10:0] o_address, o_operand;
  logic [1:0] o_sel_a;
  logic o_sel_b, o_enb_acc, o_operation, o_wr_enb_ram, o_rd_enb_ram, o_busy, o_done, o_illegal;
  typedef struct packed {
    logic [10:0] addr;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic sel_b, enb, op, wr, rd, busy, done, ill;
  } out_t;
  typedef struct {
    logic rst, start;
    logic [15:0] instr;
    logic accz;
    out_t exp;
  } vec_t;
  vec_t vq[$];
  int n_vec = 0, n_bad = 0;
  out_t act;
  always #5 i_clock = ~i_clock;
  bip_sequencer dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_instruction(i_instruction),
    .i_acc_zero(i_acc_zero), .o_address(o_address), .o_operand(o_operand), .o_sel_a(o_sel_a),
    .o_sel_b(o_sel_b), .o_enb_acc(o_enb_acc), .o_operation(o_operation),
    .o_wr_enb_ram(o_wr_enb_ram), .o_rd_enb_ram(o_rd_enb_ram), .o_busy(o_busy),
    .o_done(o_done), .o_illegal(o_illegal)
  );
  assign act = {o_address, o_operand, o_sel_a, o_sel_b, o_enb_acc, o_operation,
                o_wr_enb_ram, o_rd_enb_ram, o_busy, o_done, o_illegal};
  function automatic logic [15:0] ins(logic [4:0] opc, logic [10:0] a);
    return {opc, a};
  endfunction
  function automatic out_t o(logic [10:0] addr, logic [10:0] operand, logic [1:0] sel_a,
                             logic sel_b, logic enb, logic op, logic wr, logic rd,
                             logic busy, logic done, logic ill);
    return {addr, operand, sel_a, sel_b, enb, op, wr, rd, busy, done, ill};
  endfunction
  function automatic void push(logic rst, logic start, logic [15:0] instr, logic accz, out_t exp);
    vec_t v;
    v.rst = rst; v.start = start; v.instr = instr; v.accz = accz; v.exp = exp;
    vq.push_back(v);
  endfunction
  function automatic void idle(logic start, logic [10:0] addr);
    push(1'b0, start, 16'h0, 1'b0, o(addr, 11'h0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
  endfunction
  function automatic void fetch(logic [10:0] addr, logic start = 1'b0);
    push(1'b0, start, 16'h0, 1'b0, o(addr, 11'h0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0));
  endfunction
  function automatic void ex(logic [15:0] instr, logic accz, logic [10:0] addr, logic [1:0] sel_a,
                             logic sel_b, logic enb, logic op, logic wr, logic rd, logic done, logic ill);
    push(1'b0, 1'b0, instr, accz, o(addr, instr[10:0], sel_a, sel_b, enb, op, wr, rd, 1'b1, done, ill));
  endfunction
  task automatic check(string name, out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    push(1'b1, 1'b0, 16'h0, 1'b0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(0, 0);
    idle(1, 0);
    fetch(0);        ex(ins(5'b00011, 11'd5), 0, 11'h000, 2'd1, 0, 1, 0, 0, 0, 0, 0);
    fetch(1);        ex(ins(5'b00101, 11'd3), 0, 11'h001, 2'd2, 1, 1, 0, 0, 0, 0, 0);
    fetch(2);        ex(ins(5'b00000, 11'd0), 0, 11'h002, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    idle(1, 2);
    idle(0, 2);
    idle(1, 2);
    fetch(0);        ex(ins(5'b01000, 11'h7FF), 0, 11'h000, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    fetch(11'h7FF);  ex(ins(5'b00100, 11'h010), 0, 11'h7FF, 2'd2, 0, 1, 0, 0, 1, 0, 0);
    fetch(11'h000);  ex(ins(5'b01001, 11'h010), 1, 11'h000, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    fetch(11'h010);  ex(ins(5'b01001, 11'h020), 0, 11'h010, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    fetch(11'h011);  ex(16'hFFFF, 0, 11'h011, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    fetch(11'h012, 1); ex(ins(5'b00110, 11'd4), 0, 11'h012, 2'd2, 0, 1, 1, 0, 1, 0, 0);
    fetch(11'h013);  ex(ins(5'b00111, 11'd9), 0, 11'h013, 2'd2, 1, 1, 1, 0, 0, 0, 0);
    fetch(11'h014);  ex(ins(5'b00010, 11'd7), 0, 11'h014, 2'd0, 0, 1, 0, 0, 1, 0, 0);
    fetch(11'h015);  ex(ins(5'b01010, 11'd3), 0, 11'h015, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    fetch(11'h016);  ex(ins(5'b00001, 11'd8), 0, 11'h016, 2'd0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge i_clock);
      i_reset = vq[i].rst;
      i_start = vq[i].start;
      i_instruction = vq[i].instr;
      i_acc_zero = vq[i].accz;
      #1 check($sformatf("vec%0d", i), vq[i].exp);
    end
    // still inside the STO execute cycle: async reset must clear everything before the edge
    #1 i_reset = 1'b1;
    #1 check("rst_mid_sto", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge i_clock);
    i_reset = 1'b0; i_start = 1'b0; i_instruction = '0;
    #1 check("post_rst_idle0", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge i_clock);
    #1 check("post_rst_idle1", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge i_clock);
    i_start = 1'b1;
    #1 check("restart_idle", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge i_clock);
    #1 check("restart_fetch", o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge i_clock);
    i_start = 1'b0; i_instruction = ins(5'b00011, 11'd1);
    #1 check("restart_exec", o(0, 11'd1, 2'd1, 0, 1, 0, 0, 0, 1, 0, 0));
    @(negedge i_clock);
    i_instruction = '0;
    #1 check("restart_fetch1", o(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bip_sequencer.md
BIP_SEQUENCER -- requirements
Module: bip_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NB_INSTRUCTION, 16, instruction word width.
- NB_OPCODE, 5, opcode field width (instruction MSBs).
- NB_ADDR, 11, program-counter / ROM address width; operand field = instruction[NB_ADDR-1:0].
- NB_SELECTOR_A, 2, accumulator-input mux selector width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clock, in, 1, sole clock, rising edge.
- i_reset, in, 1, asynchronous active-high reset.
- i_start, in, 1, run request, sampled only in IDLE.
- i_instruction, in, NB_INSTRUCTION, ROM data, valid one cycle after o_address.
- i_acc_zero, in, 1, accumulator==0 flag from datapath.
- o_address, out, NB_ADDR, program counter to ROM.
- o_operand, out, NB_ADDR, instruction[NB_ADDR-1:0] passthrough.
- o_sel_a, out, NB_SELECTOR_A, 0=RAM data, 1=immediate, 2=ALU result.
- o_sel_b, out, 1, ALU operand B: 0=RAM data, 1=immediate.
- o_enb_acc, out, 1, accumulator load enable.
- o_operation, out, 1, ALU op: 0=add, 1=sub.
- o_wr_enb_ram, out, 1, data RAM write enable.
- o_rd_enb_ram, out, 1, data RAM read enable.
- o_busy, out, 1, high in FETCH and EXECUTE.
- o_done, out, 1, one-cycle pulse on HLT execution.
- o_illegal, out, 1, one-cycle pulse on undefined opcode.
REQ-003 Clocking: one clock; reset is asynchronous and active-high on i_reset.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, EXECUTE, HALTED.
REQ-005 IDLE: i_start=1 SHALL clear PC to 0 and go to FETCH; otherwise stay.
REQ-006 FETCH SHALL present PC on o_address, assert no control strobe, and go to EXECUTE next cycle (ROM latency exactly 1).
REQ-007 EXECUTE SHALL decode i_instruction and drive control outputs combinationally for exactly that cycle; all strobes SHALL be 0 in every other state.
REQ-008 Decode: HLT 00000 none; STO 00001 wr_enb_ram; LD 00010 rd_enb_ram, sel_a=0, enb_acc; LDI 00011 sel_a=1, enb_acc; ADD 00100 rd_enb_ram, sel_a=2, sel_b=0, op=0, enb_acc; ADDI 00101 sel_a=2, sel_b=1, op=0, enb_acc; SUB 00110 as ADD with op=1; SUBI 00111 as ADDI with op=1; JMP 01000 none; BEQZ 01001 none.
REQ-009 Next PC from EXECUTE: JMP -> operand; BEQZ with i_acc_zero=1 -> operand; BEQZ with i_acc_zero=0 and all other non-HLT opcodes -> PC+1 modulo 2^NB_ADDR; then FETCH.
REQ-010 PC at 2^NB_ADDR-1 SHALL wrap to 0 silently.
REQ-011 HLT in EXECUTE SHALL pulse o_done, hold PC, go to HALTED; HALTED SHALL go to IDLE next cycle.
REQ-012 Undefined opcodes SHALL act as NOP (PC+1), pulse o_illegal, assert no strobe.
REQ-013 i_start outside IDLE SHALL be ignored; o_busy SHALL be 0 in IDLE and HALTED.
REQ-014 Throughput SHALL be exactly 2 cycles per instruction.

Reset
REQ-015 i_reset SHALL immediately force IDLE, PC=0, and every output to 0, including mid-instruction; first FETCH after release requires i_start.

Structure
REQ-016 Opcode codes, sel_a codes and state encoding SHALL reside in shared package bip_pkg.
REQ-017 Decode SHALL be a combinational sub-module bip_opcode_decoder; PC and FSM stay in bip_sequencer.

Verification
REQ-018 Reset then i_start, ROM {LDI 5, ADDI 3, HLT} -> addresses 0,1,2; LDI: sel_a=1, enb_acc=1; ADDI: sel_a=2, sel_b=1, op=0; o_done at cycle 6 after start; IDLE.
REQ-019 JMP 0x7FF at PC 0, then ADD at 0x7FF -> o_address=0x7FF; after ADD next o_address=0x000 (wrap).
REQ-020 BEQZ 0x010 with i_acc_zero=1 -> next address 0x010; with i_acc_zero=0 -> PC+1.
REQ-021 Opcode 11111 -> o_illegal pulse one cycle, all strobes 0, PC+1.
REQ-022 i_reset asserted during STO EXECUTE -> o_wr_enb_ram drops same cycle, o_address=0, state IDLE; i_start during FETCH ignored.
